// File: rtl/rv_lsu_if.sv
// Request, response and memory-bus bundle for rv_lsu.
// slave = the LSU itself; master = the core and memory side that drives it.
interface rv_lsu_if #(
  parameter int XLEN = 32
) ();
  localparam int B = XLEN / 8;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [31:0]     req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_fault;
  logic [3:0]      rsp_cause;

  logic            mem_req;
  logic [31:0]     mem_addr;
  logic [B-1:0]    mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_fault, rsp_cause,
    output mem_req, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_fault, rsp_cause,
    input  mem_req, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/rv_lsu.sv
// RISC-V load/store unit: one outstanding request, one or two bus beats per access.
// Define RV_LSU_MISALIGN_EN to serve misaligned accesses instead of trapping them.
module rv_lsu #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0080_0000
) (
  input logic     clk,
  input logic     rst,
  rv_lsu_if.slave bus
);
  // state  | meaning
  // IDLE   | waiting for a request (req_ready = 1)
  // ISSUE0 | first beat presented on the bus until granted
  // WAIT0  | first beat granted, waiting for completion
  // ISSUE1 | second beat of a word-crossing access
  // WAIT1  | second beat granted, waiting for completion
  // RESP   | one-cycle response pulse
  localparam int B    = XLEN / 8;
  localparam int OFFW = $clog2(B);

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_e;
  state_e state_q, state_d;

  logic              we_q, uns_q, fault_q, split_q;
  logic [1:0]        size_q;
  logic [3:0]        cause_q;
  logic [31:0]       addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [2*XLEN-1:0] rbuf_q;

  logic [3:0]        req_nbytes;
  logic [32:0]       req_end, mem_lim;
  logic              req_oob, req_split, req_fault;
  logic [3:0]        req_cause;
`ifdef RV_LSU_MISALIGN_EN
`else
  logic [2:0]        req_amask;
  logic              req_misal;
`endif

  always_comb begin
    req_nbytes = 4'd1 << bus.req_funct3[1:0];
    // 33-bit end address so a wrap past 4 GiB shows up in bit 32
    req_end    = {1'b0, bus.req_addr} + {29'd0, req_nbytes} - 33'd1;
    mem_lim    = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    req_oob    = (bus.req_addr < MEM_BASE) || req_end[32] || (req_end >= mem_lim)
                 || ((XLEN == 32) && (bus.req_funct3[1:0] == 2'd3));
`ifdef RV_LSU_MISALIGN_EN
    req_split  = (5'(bus.req_addr[OFFW-1:0]) + 5'(req_nbytes)) > 5'(B);
    req_fault  = req_oob;
    req_cause  = bus.req_we ? 4'd7 : 4'd5;
`else
    req_amask  = 3'(req_nbytes - 4'd1);
    req_misal  = (bus.req_addr[2:0] & req_amask) != 3'd0;
    req_split  = 1'b0;
    req_fault  = req_misal || req_oob;
    req_cause  = req_misal ? (bus.req_we ? 4'd6 : 4'd4) : (bus.req_we ? 4'd7 : 4'd5);
`endif
  end

  logic [OFFW-1:0]   off;
  logic [31:0]       base;
  logic [2*B-1:0]    strb_w;
  logic [2*XLEN-1:0] wdata_sh, wdata_w, rsh;
  logic [XLEN-1:0]   ld_ext;
  logic              ld_sgn;
  int                nbits;

  // Lanes are laid out over a two-word window: low half = beat 0, high half = beat 1.
  always_comb begin
    off      = addr_q[OFFW-1:0];
    base     = {addr_q[31:OFFW], {OFFW{1'b0}}};
    wdata_sh = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
    for (int i = 0; i < 2*B; i++) begin
      strb_w[i]         = (i >= int'(off)) && (i < int'(off) + (1 << size_q));
      wdata_w[8*i +: 8] = strb_w[i] ? wdata_sh[8*i +: 8] : 8'h00;
    end
    rsh   = rbuf_q >> {off, 3'b000};
    nbits = 8 << size_q;
    case (size_q)
      2'd0:    ld_sgn = rsh[7];
      2'd1:    ld_sgn = rsh[15];
      2'd2:    ld_sgn = rsh[31];
      default: ld_sgn = rsh[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++)
      ld_ext[i] = (i < nbits) ? rsh[i] : (!uns_q && ld_sgn);
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE) && !rst;
    bus.mem_req   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wstrb = '0;
    bus.mem_wdata = '0;
    if (state_q == ISSUE0) begin
      bus.mem_req  = 1'b1;
      bus.mem_addr = base;
      if (we_q) begin
        bus.mem_wstrb = strb_w[B-1:0];
        bus.mem_wdata = wdata_w[XLEN-1:0];
      end
    end else if (state_q == ISSUE1) begin
      bus.mem_req  = 1'b1;
      bus.mem_addr = base + 32'(B);
      if (we_q) begin
        bus.mem_wstrb = strb_w[2*B-1:B];
        bus.mem_wdata = wdata_w[2*XLEN-1:XLEN];
      end
    end
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_fault = (state_q == RESP) && fault_q;
    bus.rsp_cause = ((state_q == RESP) && fault_q) ? cause_q : 4'd0;
    bus.rsp_rdata = ((state_q == RESP) && !fault_q && !we_q) ? ld_ext : '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid)  state_d = req_fault ? RESP : ISSUE0;
      ISSUE0:  if (bus.mem_gnt)    state_d = WAIT0;
      WAIT0:   if (bus.mem_rvalid) state_d = split_q ? ISSUE1 : RESP;
      ISSUE1:  if (bus.mem_gnt)    state_d = WAIT1;
      WAIT1:   if (bus.mem_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      split_q <= 1'b0;
      size_q  <= 2'd0;
      cause_q <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_funct3[2];
        size_q  <= bus.req_funct3[1:0];
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        fault_q <= req_fault;
        cause_q <= req_cause;
        split_q <= req_split;
        rbuf_q  <= '0;
      end
      if (state_q == WAIT0 && bus.mem_rvalid) rbuf_q[XLEN-1:0]      <= bus.mem_rdata;
      if (state_q == WAIT1 && bus.mem_rvalid) rbuf_q[2*XLEN-1:XLEN] <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_rv_lsu.sv
// Scoreboard bench for rv_lsu (XLEN = 32): expected responses and bus beats are queued
// at stimulus time and checked when the DUT produces them.
module tb_rv_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_lsu_if #(.XLEN(32)) bus ();
  rv_lsu #(.XLEN(32)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  cause;
    int          lat;
  } rsp_t;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } beat_t;

  rsp_t        exp_q[$];
  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, t_acc = 0;
  int          gnt_delay = 0, rv_delay = 0;
  string       cur_tag = "init";

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (bus.req_valid && bus.req_ready) t_acc = cyc;
    cyc++;
  end

  // response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (bus.rsp_valid) begin
      check_eq({cur_tag, "_ready_in_resp"}, 64'(bus.req_ready), 64'd0);
      if (exp_q.size() == 0) begin
        check_eq({cur_tag, "_unexpected_rsp"}, 64'(bus.rsp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq({cur_tag, "_rdata"}, 64'(bus.rsp_rdata), 64'(e.rdata));
        check_eq({cur_tag, "_fault"}, 64'(bus.rsp_fault), 64'(e.fault));
        check_eq({cur_tag, "_cause"}, 64'(bus.rsp_cause), 64'(e.cause));
        check_eq({cur_tag, "_latency"}, 64'(cyc - t_acc), 64'(e.lat));
      end
    end
  end

  // memory responder: grant after gnt_delay cycles, complete rv_delay+1 cycles after grant
  int          wcnt = 0, rv_cnt = -1;
  logic [31:0] rv_data = '0, stab_addr = '0, stab_wdata = '0;
  logic [3:0]  stab_strb = '0;
  always @(negedge clk) begin
    beat_t       b;
    logic [31:0] wmask;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    if (rv_cnt == 0) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rv_data;
    end
    if (rv_cnt >= 0) rv_cnt--;
    if (bus.mem_req) begin
      if (wcnt == 0) begin
        stab_addr  = bus.mem_addr;
        stab_strb  = bus.mem_wstrb;
        stab_wdata = bus.mem_wdata;
      end else begin
        check_eq({cur_tag, "_stable_addr"}, 64'(bus.mem_addr), 64'(stab_addr));
        check_eq({cur_tag, "_stable_strb"}, 64'(bus.mem_wstrb), 64'(stab_strb));
        check_eq({cur_tag, "_stable_wdata"}, 64'(bus.mem_wdata), 64'(stab_wdata));
      end
      if (wcnt >= gnt_delay) begin
        bus.mem_gnt = 1'b1;
        wcnt = 0;
        if (beat_q.size() == 0) begin
          check_eq({cur_tag, "_unexpected_mem_req"}, 64'(bus.mem_req), 64'd0);
        end else begin
          b = beat_q.pop_front();
          for (int k = 0; k < 4; k++) wmask[8*k +: 8] = {8{bus.mem_wstrb[k]}};
          check_eq({cur_tag, "_beat_addr"}, 64'(bus.mem_addr), 64'(b.addr));
          check_eq({cur_tag, "_beat_strb"}, 64'(bus.mem_wstrb), 64'(b.strb));
          check_eq({cur_tag, "_beat_wdata"}, 64'(bus.mem_wdata & wmask), 64'(b.wdata));
        end
        rv_data = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
        rv_cnt  = rv_delay;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic push_beat(input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [31:0] rd);
    beat_t b;
    b.addr = a; b.strb = s; b.wdata = d;
    beat_q.push_back(b);
    rd_q.push_back(rd);
  endtask

  task automatic issue_only(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({cur_tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic lsu_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic f, input logic [3:0] c,
                        input int lat);
    rsp_t e;
    int   n = 0;
    cur_tag = tag;
    e = '{rdata: exp_rd, fault: f, cause: c, lat: lat};
    exp_q.push_back(e);
    issue_only(we, f3, addr, wd);
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    check_eq({tag, "_beats_left"}, 64'(beat_q.size()), 64'd0);
    beat_q.delete();
    rd_q.delete();
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_mem_req", 64'(bus.mem_req), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 64'(bus.req_ready), 64'd1);
    check_eq("post_rst_rsp", 64'(bus.rsp_valid), 64'd0);

    push_beat(32'h8000_0010, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    lsu_op("lw_basic", 1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'd0, 3);
    push_beat(32'h8000_0000, 4'b0000, 32'h0, 32'h8000_0000);
    lsu_op("lb_sext", 1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'hFFFF_FF80, 1'b0, 4'd0, 3);
    push_beat(32'h8000_0000, 4'b0000, 32'h0, 32'h8000_0000);
    lsu_op("lbu_zext", 1'b0, 3'd4, 32'h8000_0003, 32'h0, 32'h0000_0080, 1'b0, 4'd0, 3);
    push_beat(32'h8000_0000, 4'b0000, 32'h0, 32'h8001_0000);
    lsu_op("lh_sext", 1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'hFFFF_8001, 1'b0, 4'd0, 3);
    push_beat(32'h8000_0000, 4'b0000, 32'h0, 32'h8001_0000);
    lsu_op("lhu_zext", 1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h0000_8001, 1'b0, 4'd0, 3);
    push_beat(32'h8000_0000, 4'b0010, 32'h0000_5A00, 32'h0);
    lsu_op("sb_lane1", 1'b1, 3'd0, 32'h8000_0001, 32'hFFFF_FF5A, 32'h0, 1'b0, 4'd0, 3);
    push_beat(32'h8000_0000, 4'b1100, 32'hABCD_0000, 32'h0);
    lsu_op("sh_upper", 1'b1, 3'd1, 32'h8000_0002, 32'h1111_ABCD, 32'h0, 1'b0, 4'd0, 3);

    gnt_delay = 5;
    push_beat(32'h8000_0020, 4'b1111, 32'hCAFE_F00D, 32'h0);
    lsu_op("sw_gnt_wait", 1'b1, 3'd2, 32'h8000_0020, 32'hCAFE_F00D, 32'h0, 1'b0, 4'd0, 8);
    gnt_delay = 0;

`ifdef RV_LSU_MISALIGN_EN
    push_beat(32'h8000_0000, 4'b1000, 32'h3400_0000, 32'h0);
    push_beat(32'h8000_0004, 4'b0001, 32'h0000_0012, 32'h0);
    lsu_op("sh_split", 1'b1, 3'd1, 32'h8000_0003, 32'h0000_1234, 32'h0, 1'b0, 4'd0, 5);
    push_beat(32'h8000_0000, 4'b0000, 32'h0, 32'h1280_0134);
    lsu_op("lh_misal_1beat", 1'b0, 3'd1, 32'h8000_0001, 32'h0, 32'hFFFF_8001, 1'b0, 4'd0, 3);
    push_beat(32'h8000_0000, 4'b0000, 32'h0, 32'h3344_9999);
    push_beat(32'h8000_0004, 4'b0000, 32'h0, 32'h7777_1122);
    lsu_op("lw_split", 1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h1122_3344, 1'b0, 4'd0, 5);
    lsu_op("lw_misal_end", 1'b0, 3'd2, 32'h807F_FFFE, 32'h0, 32'h0, 1'b1, 4'd5, 1);
    lsu_op("lh_wrap", 1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 4'd5, 1);
`else
    lsu_op("sh_misal", 1'b1, 3'd1, 32'h8000_0003, 32'h0000_1234, 32'h0, 1'b1, 4'd6, 1);
    lsu_op("lh_misal", 1'b0, 3'd1, 32'h8000_0001, 32'h0, 32'h0, 1'b1, 4'd4, 1);
    lsu_op("lw_misal", 1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h0, 1'b1, 4'd4, 1);
    lsu_op("lw_misal_end", 1'b0, 3'd2, 32'h807F_FFFE, 32'h0, 32'h0, 1'b1, 4'd4, 1);
    lsu_op("lh_wrap", 1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 4'd4, 1);
`endif

    push_beat(32'h807F_FFFC, 4'b0000, 32'h0, 32'h1122_3344);
    lsu_op("lw_top", 1'b0, 3'd2, 32'h807F_FFFC, 32'h0, 32'h1122_3344, 1'b0, 4'd0, 3);
    lsu_op("lw_past_end", 1'b0, 3'd2, 32'h8080_0000, 32'h0, 32'h0, 1'b1, 4'd5, 1);
    lsu_op("sw_below", 1'b1, 3'd2, 32'h7FFF_FFFC, 32'h5555_AAAA, 32'h0, 1'b1, 4'd7, 1);
    lsu_op("lbu_below", 1'b0, 3'd4, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b1, 4'd5, 1);
    lsu_op("lw_high", 1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 4'd5, 1);
    lsu_op("ld_xlen32", 1'b0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 4'd5, 1);
    lsu_op("sd_xlen32", 1'b1, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 4'd7, 1);

    // reset while a beat waits for grant: mem_req must drop without a clock edge
    cur_tag   = "rst_issue";
    gnt_delay = 20;
    push_beat(32'h8000_0040, 4'b0000, 32'h0, 32'h0);
    issue_only(1'b0, 3'd2, 32'h8000_0040, 32'h0);
    check_eq("rst_issue_req_before", 64'(bus.mem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_issue_mem_req", 64'(bus.mem_req), 64'd0);
    check_eq("rst_issue_mem_addr", 64'(bus.mem_addr), 64'd0);
    check_eq("rst_issue_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_issue_rsp", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    beat_q.delete();
    rd_q.delete();
    gnt_delay = 0;
    #1 check_eq("rst_issue_ready_after", 64'(bus.req_ready), 64'd1);

    // reset in WAIT0, completion arrives afterwards and must be ignored
    cur_tag  = "rst_wait0";
    rv_delay = 3;
    push_beat(32'h8000_0050, 4'b0000, 32'h0, 32'h5555_5555);
    issue_only(1'b0, 3'd2, 32'h8000_0050, 32'h0);
    @(negedge clk);
    check_eq("rst_wait0_no_req", 64'(bus.mem_req), 64'd0);
    #2 rst = 1'b1;
    #1 check_eq("rst_wait0_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("rst_wait0_ready_after", 64'(bus.req_ready), 64'd1);
    check_eq("rst_wait0_beats", 64'(beat_q.size()), 64'd0);
    rv_delay = 0;
    rd_q.delete();

    push_beat(32'h8000_0060, 4'b0000, 32'h0, 32'h0BAD_F00D);
    lsu_op("lw_after_rst", 1'b0, 3'd2, 32'h8000_0060, 32'h0, 32'h0BAD_F00D, 1'b0, 4'd0, 3);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
